// File: rtl/currctrl_reg_sequencer.sv
// currctrl_reg_sequencer
// Owns port 2 of the current-control register RAM. On each control tick it
// streams the setpoint words out, then writes back the measurement snapshot
// and a status word. Between ticks it serves one auxiliary access.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | bus idle; waits for a tick, a pending tick or an aux request
// RD       | reading setpoint word SP_BASE+idx
// WR       | writing sign-extended measurement word MEAS_BASE+idx
// STAT     | writing status word {overrun_cnt, tick_cnt}
// AUX      | performing the latched aux access
// AUX_WAIT | capturing RAM read data for the aux requester
// AUX_ACK  | aux_ack pulse, then back to IDLE
module currctrl_reg_sequencer #(
    parameter int unsigned NUM_CH    = 4,
    parameter logic [7:0]  SP_BASE   = 8'h00,
    parameter logic [7:0]  MEAS_BASE = 8'h10,
    parameter logic [7:0]  STAT_ADDR = 8'h20,
    parameter int unsigned MEAS_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tick,
    input  logic [NUM_CH*MEAS_W-1:0] meas_data,
    input  logic                     ovr_clr,
    input  logic                     aux_req,
    input  logic                     aux_write,
    input  logic [7:0]               aux_addr,
    input  logic [3:0]               aux_be,
    input  logic [31:0]              aux_wdata,
    output logic                     aux_ack,
    output logic [31:0]              aux_rdata,
    output logic [7:0]               ram_address,
    output logic                     ram_chipselect,
    output logic                     ram_write,
    output logic [3:0]               ram_byteenable,
    output logic [31:0]              ram_writedata,
    input  logic [31:0]              ram_readdata,
    output logic                     sp_valid,
    output logic [3:0]               sp_index,
    output logic [31:0]              sp_data,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    typedef enum logic [2:0] {
        IDLE, RD, WR, STAT, AUX, AUX_WAIT, AUX_ACK
    } state_t;

    localparam logic [3:0]  LAST_IDX = 4'(NUM_CH - 1);
    localparam int unsigned SNAP_W   = NUM_CH * MEAS_W;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [SNAP_W-1:0]  snap_q, snap_d;
    logic               pend_q, pend_d;
    logic               overrun_q, overrun_d;
    logic [15:0]        ovr_cnt_q, ovr_cnt_d;
    logic [15:0]        tick_cnt_q, tick_cnt_d;
    logic               done_q, done_d;
    logic               aux_write_q, aux_write_d;
    logic [7:0]         aux_addr_q, aux_addr_d;
    logic [3:0]         aux_be_q, aux_be_d;
    logic [31:0]        aux_wdata_q, aux_wdata_d;
    logic [31:0]        aux_rdata_q, aux_rdata_d;
    logic               rd_v_q, rd_v_d;
    logic [3:0]         rd_idx_q, rd_idx_d;
    logic               sp_valid_q, sp_valid_d;
    logic [3:0]         sp_index_q, sp_index_d;
    logic [31:0]        sp_data_q, sp_data_d;

    logic               accept_tick;
    logic               accept_aux;
    logic               in_seq;
    logic               in_aux;
    logic               tick_drop;
    logic               tick_hold;
    logic [MEAS_W-1:0]  meas_sel;
    logic [31:0]        meas_ext;

    assign meas_sel = snap_q[32'(idx_q) * MEAS_W +: MEAS_W];
    assign meas_ext = {{(32 - MEAS_W){meas_sel[MEAS_W-1]}}, meas_sel};

    // Next-state decode and RAM port drive; tick beats aux when both arrive in IDLE.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        accept_tick    = 1'b0;
        accept_aux     = 1'b0;
        aux_ack        = 1'b0;
        ram_address    = 8'h00;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_byteenable = 4'h0;
        ram_writedata  = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (tick || pend_q) begin
                    state_d     = RD;
                    idx_d       = 4'h0;
                    accept_tick = 1'b1;
                end else if (aux_req) begin
                    state_d    = AUX;
                    accept_aux = 1'b1;
                end
            end
            RD: begin
                ram_address    = SP_BASE + {4'h0, idx_q};
                ram_chipselect = 1'b1;
                ram_byteenable = 4'hF;
                if (idx_q == LAST_IDX) begin
                    state_d = WR;
                    idx_d   = 4'h0;
                end else begin
                    idx_d = idx_q + 4'h1;
                end
            end
            WR: begin
                ram_address    = MEAS_BASE + {4'h0, idx_q};
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_byteenable = 4'hF;
                ram_writedata  = meas_ext;
                if (idx_q == LAST_IDX) begin
                    state_d = STAT;
                    idx_d   = 4'h0;
                end else begin
                    idx_d = idx_q + 4'h1;
                end
            end
            STAT: begin
                ram_address    = STAT_ADDR;
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_byteenable = 4'hF;
                ram_writedata  = {ovr_cnt_q, tick_cnt_q};
                state_d        = IDLE;
            end
            AUX: begin
                ram_address    = aux_addr_q;
                ram_chipselect = 1'b1;
                ram_write      = aux_write_q;
                ram_byteenable = aux_be_q;
                ram_writedata  = aux_wdata_q;
                state_d        = AUX_WAIT;
            end
            AUX_WAIT: state_d = AUX_ACK;
            AUX_ACK: begin
                aux_ack = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Tick bookkeeping, counters, aux latch and the setpoint read pipeline.
    always_comb begin
        in_seq    = (state_q == RD) || (state_q == WR) || (state_q == STAT);
        in_aux    = (state_q == AUX) || (state_q == AUX_WAIT) || (state_q == AUX_ACK);
        // A pending tick can only hold one: any further tick is lost.
        tick_drop = tick && (in_seq || pend_q);
        tick_hold = tick && in_aux && !pend_q;

        pend_d    = tick_hold ? 1'b1 : (accept_tick ? 1'b0 : pend_q);
        overrun_d = tick_drop ? 1'b1 : (ovr_clr ? 1'b0 : overrun_q);
        ovr_cnt_d = (tick_drop && (ovr_cnt_q != 16'hFFFF)) ? ovr_cnt_q + 16'h1 : ovr_cnt_q;
        tick_cnt_d = (state_q == STAT) ? tick_cnt_q + 16'h1 : tick_cnt_q;
        done_d    = (state_q == STAT);
        snap_d    = accept_tick ? meas_data : snap_q;

        aux_write_d = accept_aux ? aux_write : aux_write_q;
        aux_addr_d  = accept_aux ? aux_addr  : aux_addr_q;
        aux_be_d    = accept_aux ? aux_be    : aux_be_q;
        aux_wdata_d = accept_aux ? aux_wdata : aux_wdata_q;
        aux_rdata_d = (state_q == AUX_WAIT) ? ram_readdata : aux_rdata_q;

        // RAM address is registered inside the RAM, so data for an RD cycle
        // shows up one cycle later and is then registered onto sp_*.
        rd_v_d     = (state_q == RD);
        rd_idx_d   = idx_q;
        sp_valid_d = rd_v_q;
        sp_index_d = rd_v_q ? rd_idx_q : sp_index_q;
        sp_data_d  = rd_v_q ? ram_readdata : sp_data_q;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Datapath, counter and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            snap_q      <= '0;
            pend_q      <= 1'b0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= 16'h0;
            tick_cnt_q  <= 16'h0;
            done_q      <= 1'b0;
            aux_write_q <= 1'b0;
            aux_addr_q  <= 8'h0;
            aux_be_q    <= 4'h0;
            aux_wdata_q <= 32'h0;
            aux_rdata_q <= 32'h0;
            rd_v_q      <= 1'b0;
            rd_idx_q    <= 4'h0;
            sp_valid_q  <= 1'b0;
            sp_index_q  <= 4'h0;
            sp_data_q   <= 32'h0;
        end else begin
            snap_q      <= snap_d;
            pend_q      <= pend_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            done_q      <= done_d;
            aux_write_q <= aux_write_d;
            aux_addr_q  <= aux_addr_d;
            aux_be_q    <= aux_be_d;
            aux_wdata_q <= aux_wdata_d;
            aux_rdata_q <= aux_rdata_d;
            rd_v_q      <= rd_v_d;
            rd_idx_q    <= rd_idx_d;
            sp_valid_q  <= sp_valid_d;
            sp_index_q  <= sp_index_d;
            sp_data_q   <= sp_data_d;
        end
    end

    assign aux_rdata = aux_rdata_q;
    assign sp_valid  = sp_valid_q;
    assign sp_index  = sp_index_q;
    assign sp_data   = sp_data_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_currctrl_reg_sequencer.sv
// Bench for currctrl_reg_sequencer: behavioural 256x32 RAM on port 2,
// table of measurement patterns, and hand-built tick/aux corner sequences.
module tb_currctrl_reg_sequencer;

    logic        clk;
    logic        reset_n;
    logic        tick;
    logic [63:0] meas_data;
    logic        ovr_clr;
    logic        aux_req;
    logic        aux_write;
    logic [7:0]  aux_addr;
    logic [3:0]  aux_be;
    logic [31:0] aux_wdata;
    logic        aux_ack;
    logic [31:0] aux_rdata;
    logic [7:0]  ram_address;
    logic        ram_chipselect;
    logic        ram_write;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;
    logic        sp_valid;
    logic [3:0]  sp_index;
    logic [31:0] sp_data;
    logic        busy;
    logic        done;
    logic        overrun;

    currctrl_reg_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .tick           (tick),
        .meas_data      (meas_data),
        .ovr_clr        (ovr_clr),
        .aux_req        (aux_req),
        .aux_write      (aux_write),
        .aux_addr       (aux_addr),
        .aux_be         (aux_be),
        .aux_wdata      (aux_wdata),
        .aux_ack        (aux_ack),
        .aux_rdata      (aux_rdata),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_byteenable (ram_byteenable),
        .ram_writedata  (ram_writedata),
        .ram_readdata   (ram_readdata),
        .sp_valid       (sp_valid),
        .sp_index       (sp_index),
        .sp_data        (sp_data),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: address registered on clk, read data combinational from it.
    logic [31:0] mem [256];
    logic [7:0]  addr_r;
    logic        mem_init;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i < 4) ? 32'(i + 1) : 32'h0;
            addr_r <= 8'h00;
        end else begin
            addr_r <= ram_address;
            if (ram_chipselect && ram_write)
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
    end
    assign ram_readdata = mem[addr_r];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [3:0]  idx;
        logic [31:0] data;
    } sp_exp_t;
    typedef struct {
        logic        care;
        logic [31:0] data;
    } aux_exp_t;

    sp_exp_t  sp_q [$];
    aux_exp_t aux_q [$];
    sp_exp_t  sp_e;
    aux_exp_t aux_e;

    // Setpoint stream scoreboard.
    always @(negedge clk) begin
        if (sp_valid) begin
            if (sp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sp_unexpected: actual index=%0d data=%h required=no output", sp_index, sp_data);
            end else begin
                sp_e = sp_q.pop_front();
                chk("sp_cycle", 32'(cyc), 32'(sp_e.cyc));
                chk("sp_index", {28'h0, sp_index}, {28'h0, sp_e.idx});
                chk("sp_data", sp_data, sp_e.data);
            end
        end
    end

    // Aux read-data scoreboard.
    always @(negedge clk) begin
        if (aux_ack) begin
            if (aux_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL aux_unexpected: actual ack=1 required=no ack");
            end else begin
                aux_e = aux_q.pop_front();
                if (aux_e.care) chk("aux_rdata", aux_rdata, aux_e.data);
            end
        end
    end

    typedef struct {
        logic [63:0]      meas;
        logic [3:0][31:0] exp_w;
    } vec_t;
    vec_t tbl [3];

    logic [15:0] n_ticks;
    logic [15:0] ovr_exp;
    int          t;
    int          a;

    task automatic push_sp(input int t0);
        for (int i = 0; i < 4; i++) sp_q.push_back('{t0 + 3 + i, 4'(i), 32'(i + 1)});
    endtask

    task automatic do_tick(output int t0);
        @(posedge clk); #1;
        tick = 1'b1;
        t0 = cyc;
        push_sp(t0);
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic wait_done(input int t0, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        chk(nm, 32'(cyc), 32'(t0 + 10));
    endtask

    task automatic start_aux(input logic w, input logic [7:0] ad, input logic [3:0] be,
                             input logic [31:0] wd, input logic care, input logic [31:0] rd,
                             output int acc);
        @(posedge clk); #1;
        aux_req   = 1'b1;
        aux_write = w;
        aux_addr  = ad;
        aux_be    = be;
        aux_wdata = wd;
        acc       = cyc;
        aux_q.push_back('{care, rd});
    endtask

    task automatic wait_ack(input int exp_cyc, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!aux_ack && n < 60);
        chk(nm, 32'(cyc), 32'(exp_cyc));
        aux_req   = 1'b0;
        aux_write = 1'b0;
    endtask

    task automatic check_meas(input int k);
        for (int i = 0; i < 4; i++) chk("meas_word", mem[8'h10 + i], tbl[k].exp_w[i]);
    endtask

    task automatic check_stat();
        chk("stat_word", mem[8'h20], {ovr_exp, n_ticks});
        n_ticks = n_ticks + 16'h1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        mem_init  = 1'b1;
        tick      = 1'b0;
        meas_data = 64'h0;
        ovr_clr   = 1'b0;
        aux_req   = 1'b0;
        aux_write = 1'b0;
        aux_addr  = 8'h0;
        aux_be    = 4'h0;
        aux_wdata = 32'h0;
        n_ticks   = 16'h0;
        ovr_exp   = 16'h0;

        tbl[0].meas  = {16'hFFFF, 16'h7FFF, 16'h0001, 16'h8000};
        tbl[0].exp_w = {32'hFFFFFFFF, 32'h00007FFF, 32'h00000001, 32'hFFFF8000};
        tbl[1].meas  = {16'h1234, 16'h0000, 16'hABCD, 16'h7FFE};
        tbl[1].exp_w = {32'h00001234, 32'h00000000, 32'hFFFFABCD, 32'h00007FFE};
        tbl[2].meas  = {16'h8001, 16'h00FF, 16'hFF00, 16'h0000};
        tbl[2].exp_w = {32'hFFFF8001, 32'h000000FF, 32'hFFFFFF00, 32'h00000000};

        repeat (3) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        mem_init = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        chk("rst_sp_valid", {31'h0, sp_valid}, 32'h0);
        chk("rst_aux_ack", {31'h0, aux_ack}, 32'h0);
        chk("rst_bus", {20'h0, ram_chipselect, ram_write, ram_byteenable, ram_address}, 32'h0);
        chk("rst_wdata", ram_writedata, 32'h0);
        chk("rst_sp_data", sp_data, 32'h0);

        // Table: measurement snapshots, sign extension and status word.
        for (int k = 0; k < 3; k++) begin
            meas_data = tbl[k].meas;
            do_tick(t);
            meas_data = ~tbl[k].meas;
            @(negedge clk);
            chk("rd_bus", {20'h0, ram_chipselect, ram_write, ram_byteenable, ram_address},
                {20'h0, 1'b1, 1'b0, 4'hF, 8'h00});
            chk("rd_busy", {31'h0, busy}, 32'h1);
            wait_done(t, "done_cycle");
            check_meas(k);
            check_stat();
        end

        // Aux write with partial byte enables, then read back.
        start_aux(1'b1, 8'h55, 4'b0011, 32'hA5A5A5A5, 1'b0, 32'h0, a);
        wait_ack(a + 3, "aux_wr_ack_cycle");
        chk("aux_wr_mem", mem[8'h55], 32'h0000A5A5);
        start_aux(1'b0, 8'h55, 4'hF, 32'h0, 1'b1, 32'h0000A5A5, a);
        wait_ack(a + 3, "aux_rd_ack_cycle");

        // Tick and aux request in the same idle cycle: tick sequence first.
        @(posedge clk); #1;
        tick      = 1'b1;
        t         = cyc;
        push_sp(t);
        aux_req   = 1'b1;
        aux_write = 1'b0;
        aux_addr  = 8'h02;
        aux_be    = 4'hF;
        aux_q.push_back('{1'b1, 32'h00000003});
        @(posedge clk); #1;
        tick = 1'b0;
        wait_done(t, "tie_done_cycle");
        check_stat();
        wait_ack(t + 13, "tie_ack_cycle");

        // Tick during aux access is pended, sequence starts after return to IDLE.
        start_aux(1'b0, 8'h55, 4'hF, 32'h0, 1'b1, 32'h0000A5A5, a);
        @(posedge clk); #1;
        tick = 1'b1;
        push_sp(a + 4);
        @(posedge clk); #1;
        tick = 1'b0;
        wait_ack(a + 3, "pend_ack_cycle");
        @(negedge clk);
        chk("pend_idle_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("pend_rd_bus", {22'h0, busy, ram_chipselect, ram_address}, {22'h0, 1'b1, 1'b1, 8'h00});
        wait_done(a + 4, "pend_done_cycle");
        chk("pend_overrun", {31'h0, overrun}, 32'h0);
        check_stat();

        // Tick during WR is dropped.
        do_tick(t);
        repeat (5) @(posedge clk);
        #1;
        tick = 1'b1;
        ovr_exp = 16'h1;
        @(posedge clk); #1;
        tick = 1'b0;
        @(negedge clk);
        chk("drop_overrun", {31'h0, overrun}, 32'h1);
        wait_done(t, "drop_done_cycle");
        check_stat();

        // ovr_clr clears the flag, count is retained.
        @(posedge clk); #1;
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;
        @(negedge clk);
        chk("clr_overrun", {31'h0, overrun}, 32'h0);
        do_tick(t);
        wait_done(t, "clr_done_cycle");
        check_stat();

        // Drop and ovr_clr in the same cycle: the drop wins.
        do_tick(t);
        @(posedge clk); #1;
        tick    = 1'b1;
        ovr_clr = 1'b1;
        ovr_exp = 16'h2;
        @(posedge clk); #1;
        tick    = 1'b0;
        ovr_clr = 1'b0;
        @(negedge clk);
        chk("clr_vs_drop_overrun", {31'h0, overrun}, 32'h1);
        wait_done(t, "clr_vs_drop_done_cycle");
        check_stat();
        @(posedge clk); #1;
        ovr_clr = 1'b1;
        @(posedge clk); #1;
        ovr_clr = 1'b0;

        // Reset during the second WR cycle.
        meas_data = tbl[1].meas;
        do_tick(t);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        n_ticks = 16'h0;
        ovr_exp = 16'h0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("wrrst_cycle", 32'(cyc), 32'(t + 7));
        chk("wrrst_busy", {31'h0, busy}, 32'h0);
        chk("wrrst_done", {31'h0, done}, 32'h0);
        chk("wrrst_sp_valid", {31'h0, sp_valid}, 32'h0);
        chk("wrrst_cs", {31'h0, ram_chipselect}, 32'h0);
        meas_data = tbl[0].meas;
        do_tick(t);
        wait_done(t, "post_rst_done_cycle");
        check_meas(0);
        check_stat();

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sp_queue_empty", 32'(sp_q.size()), 32'h0);
        chk("aux_queue_empty", 32'(aux_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/currctrl_reg_sequencer.md
# currctrl_reg_sequencer

Control-loop sequencer for port 2 of the current-control register RAM (256 x 32, byte-enabled, address registered on `clk`, read data unregistered). On each control tick it streams the coil-channel setpoint words out of the RAM, writes back the measurement snapshot plus a status word, and grants the port to one auxiliary requester between ticks. It sits between the RAM's second port and the per-channel current-loop datapath.

## Interface
- `NUM_CH`, 4, coil channels (1..16)
- `SP_BASE`, 8'h00, first setpoint word address
- `MEAS_BASE`, 8'h10, first measurement word address
- `STAT_ADDR`, 8'h20, status word address
- `MEAS_W`, 16, measurement width, sign-extended to 32 on write
- `clk`  in  1  single clock
- `reset_n`  in  1  reset, synchronous, active-low
- `tick`  in  1  loop-period strobe, one-cycle pulse
- `meas_data`  in  NUM_CH*MEAS_W  measurements, channel 0 in LSBs
- `ovr_clr`  in  1  clears sticky `overrun`
- `aux_req`  in  1  aux access request, held until `aux_ack`
- `aux_write`, `aux_addr[7:0]`, `aux_be[3:0]`, `aux_wdata[31:0]`  in  aux command, stable while `aux_req`
- `aux_ack`  out  1  one-cycle completion pulse
- `aux_rdata`  out  32  aux read data, valid with `aux_ack`
- `ram_address`  out  8; `ram_chipselect`, `ram_write`  out  1; `ram_byteenable`  out  4; `ram_writedata`  out  32
- `ram_readdata`  in  32
- `sp_valid`  out  1; `sp_index`  out  4; `sp_data`  out  32  setpoint stream
- `busy`  out  1  not in IDLE
- `done`  out  1  one-cycle pulse, tick sequence complete
- `overrun`  out  1  sticky dropped-tick flag

## Operation
- States: IDLE, RD, WR, STAT, AUX, AUX_WAIT, AUX_ACK.
- IDLE: `tick` or `tick_pending` -> RD (snapshot `meas_data`, clear pending); else `aux_req` -> AUX (latch command). Tick wins over aux when simultaneous.
- RD: NUM_CH cycles, address SP_BASE+i, chipselect=1, write=0; then WR.
- WR: NUM_CH cycles, address MEAS_BASE+i, writedata = sign-extended snapshot channel i, write=1; then STAT.
- STAT: one write to STAT_ADDR, data {overrun_cnt[15:0], tick_cnt[15:0]} (values before this cycle's increment); then IDLE, tick_cnt += 1 (wraps).
- Sequencer accesses use byteenable 4'hF. Idle bus: chipselect=0, write=0, others 0.
- AUX: one access with latched addr/be/wdata/write; AUX_WAIT: capture `ram_readdata` into `aux_rdata` (writes capture too, content undefined); AUX_ACK: `aux_ack`=1; then IDLE.
- Tick in AUX/AUX_WAIT/AUX_ACK with no pending: set `tick_pending`. Tick in RD/WR/STAT, or while pending already set: dropped, `overrun`=1, overrun_cnt += 1 saturating at 16'hFFFF.
- `ovr_clr` clears `overrun` only; a simultaneous drop wins (flag stays 1). overrun_cnt cleared only by reset.
- Setpoint stream: read data captured one cycle after its address, registered to outputs; `sp_index`=i.

## Timing
- Tick accepted in IDLE at cycle T: RD T+1..T+NUM_CH; WR T+NUM_CH+1..T+2·NUM_CH; STAT T+2·NUM_CH+1; `done` at T+2·NUM_CH+2 (state already IDLE, a new tick accepted that cycle).
- `sp_valid` cycles T+3..T+NUM_CH+2, index 0..NUM_CH-1 in order.
- Aux accepted at A: access A+1, capture A+2, `aux_ack` A+3, IDLE at A+4 (requester drops `aux_req` at A+3 latest).
- Pending tick from aux: RD starts the cycle after return to IDLE.
- Reset (any cycle): state IDLE, all outputs 0, counters/pending/snapshot 0; partially written measurement block left as-is.

## Test plan
- NUM_CH=4, RAM[0..3]=1,2,3,4, tick at T -> `sp_valid` T+3..T+6 with data 1..4, `sp_index` 0..3; `done` at T+10.
- meas ch0..3 = 16'h8000,16'h0001,16'h7FFF,16'hFFFF -> RAM[0x10..0x13] = FFFF8000, 00000001, 00007FFF, FFFFFFFF; RAM[0x20]=00000000 after first tick, 00000001 after second.
- Aux write 0x55 data 32'hA5A5A5A5 be 4'b0011, then aux read 0x55 over prior 0 -> `aux_rdata`=0000A5A5, each `aux_ack` 3 cycles after acceptance.
- Tick and `aux_req` same idle cycle -> tick sequence first, aux acked after `done`; tick during aux -> pended, RD starts right after AUX_ACK, `overrun`=0.
- Tick during WR -> dropped, `overrun`=1, next status word upper half 0001; `ovr_clr` -> `overrun`=0, count retained.
- `reset_n`=0 during WR cycle 2 -> next cycle IDLE, `busy`/`done`/`sp_valid`/`ram_chipselect`=0; next tick runs full sequence, status word 00000000.
